md_scheduler: RTL and testbench
===============================

Name: md_scheduler

Overview:
- Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline; owns the HI/LO registers.
- The E stage issues mult/multu/div/divu/mthi/mtlo to this block. It holds the operation busy for a fixed latency, then commits HI/LO.
- It tells the hazard logic to stall the D stage while any HI/LO-using instruction (mult/div/mfhi/mflo/mthi/mtlo) would collide with an operation in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..31).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..31).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage HI/LO instruction valid this cycle.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved.
- a  input  32  rs operand (multiplicand / dividend / mthi-mtlo source).
- b  input  32  rt operand (multiplier / divisor).
- d_md  input  1  D-stage instruction uses HI/LO.
- busy  output  1  multiply/divide in progress.
- stall  output  1  freeze F/D, bubble into E.
- done  output  1  one-cycle pulse: HI/LO just committed by mult/div.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (sync, any state including mid-operation): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0. Any in-flight result is discarded.
- FSM states: IDLE, RUN.
- IDLE with start=1 and op in {0..3}:
  - Latch a, b and op at the edge (call it T0).
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from T0.
- RUN:
  - Counter decrements each edge. At edge T0+N (N = selected latency), write hi/lo, busy->0, done->1 for exactly one cycle, return to IDLE.
  - busy is high for exactly N cycles.
- Back-to-back issue: start in the cycle done=1 (state IDLE) is accepted normally.
- MTHI/MTLO (start=1, op 4/5, IDLE):
  - hi (or lo) <= a at the same edge; the other register is unchanged.
  - No busy, no done.
- start=1 while busy=1 is a protocol violation (stall prevents it): ignored, and the operation in flight is unaffected.
- Reserved op 6/7: ignored, no state change.
- Arithmetic, computed from the latched operands:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (b==0): full DIV_CYCLES latency and done pulse, but hi/lo keep their prior values.
- stall (combinational): stall = d_md & (busy | (start & op<=3)).
  - mthi/mtlo in E does not cause a stall.
- Outputs hi/lo are registered. mfhi/mflo read them directly, and are legal only when stall=0.
- All outputs are registered except stall.

Test Plan:
- MULTU a=0xFFFFFFFF b=2, start at T0 -> busy=1 for cycles T0..T0+4; at T0+5 hi=0x00000001, lo=0xFFFFFFFE, done=1 one cycle, busy=0.
- MULT a=0xFFFFFFFF(-1) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD after 5 cycles.
- DIV a=-7 b=2:
  - After 10 cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then DIVU a=7 b=2 issued in the done cycle -> accepted; 10 cycles later lo=3, hi=1.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then DIV by zero with prior hi/lo=(0,0x80000000) -> unchanged after 10 cycles, done still pulses.
- Hazard checks:
  - d_md=1 during start of MULT and all 5 busy cycles -> stall=1; stall=0 in the done cycle.
  - d_md=1 with start of MTLO a=0x1234 -> stall=0, lo=0x1234 next cycle.
- Reset asserted at cycle 3 of DIV -> next edge busy=0, hi=lo=0, done never pulses. A new MULT issued afterwards completes normally.

Source files
------------

// File: rtl/md_scheduler.sv
// md_scheduler: multi-cycle multiply/divide controller owning the HI/LO registers.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous active-high reset
//   start  in   1   E-stage HI/LO instruction valid this cycle
//   op     in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7 reserved
//   a      in  32   rs operand (multiplicand / dividend / mthi-mtlo source)
//   b      in  32   rt operand (multiplier / divisor)
//   d_md   in   1   D-stage instruction uses HI/LO
//   busy   out  1   multiply/divide in progress (registered)
//   stall  out  1   freeze F/D, bubble into E (combinational)
//   done   out  1   one-cycle pulse when a mult/div commits HI/LO (registered)
//   hi     out 32   HI register
//   lo     out 32   LO register
module md_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    // Arithmetic on the latched operands
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic                div_zero;
    logic                div_ovf;
    logic [DATA_W-1:0]   divs_b;
    logic [DATA_W-1:0]   divu_b;
    logic [DATA_W-1:0]   quo_s;
    logic [DATA_W-1:0]   rem_s;
    logic [DATA_W-1:0]   quo_u;
    logic [DATA_W-1:0]   rem_u;

    // Divisors are steered to 1 for b==0 (result discarded anyway) and for the
    // signed overflow case, where a/1 yields exactly the required 0x80000000 rem 0.
    always_comb begin
        prod_s   = 64'($signed(a_q)) * 64'($signed(b_q));
        prod_u   = 64'(a_q) * 64'(b_q);
        div_zero = (b_q == 32'd0);
        div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        divs_b   = (div_zero || div_ovf) ? 32'd1 : b_q;
        divu_b   = div_zero ? 32'd1 : b_q;
        quo_s    = 32'($signed(a_q) / $signed(divs_b));
        rem_s    = 32'($signed(a_q) % $signed(divs_b));
        quo_u    = a_q / divu_b;
        rem_u    = a_q % divu_b;
    end

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (op <= OP_DIVU) begin
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                // start is ignored here; the hazard logic keeps it from happening
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MULT: begin
                            hi_d = prod_s[63:32];
                            lo_d = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            hi_d = prod_u[63:32];
                            lo_d = prod_u[31:0];
                        end
                        OP_DIV: begin
                            if (!div_zero) begin
                                hi_d = rem_s;
                                lo_d = quo_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!div_zero) begin
                                hi_d = rem_u;
                                lo_d = quo_u;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stall the D stage on a HI/LO user whenever a mult/div is in flight or issuing
    assign stall = d_md & (busy_q | (start & (op <= OP_DIVU)));

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Testbench for md_scheduler: directed scenarios plus randomized operations
// checked against an arithmetic reference model of HI/LO.
module tb_md_scheduler;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .d_md  (d_md),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: HI/LO update from the architectural definition
    function automatic void model_apply(input int unsigned mop, input logic [31:0] ma,
                                        input logic [31:0] mb);
        logic [63:0] p;
        longint      sa, sb, q, r;
        logic [63:0] qv, rv;
        case (mop)
            0: begin
                p = 64'(longint'($signed(ma)) * longint'($signed(mb)));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            1: begin
                p = {32'd0, ma} * {32'd0, mb};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            2: if (mb != 32'd0) begin
                sa = longint'($signed(ma)); sb = longint'($signed(mb));
                q = sa / sb; r = sa % sb;
                qv = 64'(q); rv = 64'(r);
                m_lo = qv[31:0]; m_hi = rv[31:0];
            end
            3: if (mb != 32'd0) begin
                m_lo = ma / mb; m_hi = ma % mb;
            end
            4: m_hi = ma;
            5: m_lo = ma;
            default: ;
        endcase
    endfunction

    // Present one-cycle start; returns just after the accepting edge
    task automatic issue(input logic [2:0] iop, input logic [31:0] ia, input logic [31:0] ib);
        start = 1'b1; op = iop; a = ia; b = ib;
        tick();
        start = 1'b0; op = 3'd7; a = $urandom; b = $urandom;
    endtask

    // Counts sampled cycles (and busy cycles) until done is seen; cyc=-1 on timeout
    task automatic wait_done(output int cyc, output int bc);
        cyc = 0; bc = 0;
        while (done !== 1'b1) begin
            if (busy === 1'b1) bc++;
            if (cyc >= 64) begin
                cyc = -1;
                return;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; d_md = 1'b0;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy=%b done=%b required 0 0", busy, done);
        end
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL reset_hilo: hi=%h lo=%h required 0 0", hi, lo);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b required 0", stall);
        end
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        tick();
    endtask

    // Full check of one mult/div: latency, busy length, result, done width
    task automatic test_md_op(input string name, input logic [2:0] iop,
                              input logic [31:0] ia, input logic [31:0] ib,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                              input bit leave_done);
        int cyc, bc, n;
        n = (iop[1]) ? DIV_N : MULT_N;
        issue(iop, ia, ib);
        wait_done(cyc, bc);
        n_checks++;
        if (cyc != n) begin
            n_fail++; $display("FAIL %s_latency: got %0d required %0d", name, cyc, n);
        end
        n_checks++;
        if (bc != n) begin
            n_fail++; $display("FAIL %s_busy_len: got %0d required %0d", name, bc, n);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_busy_at_done: got %b required 0", name, busy);
        end
        n_checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_fail++; $display("FAIL %s_result: hi=%h lo=%h required hi=%h lo=%h",
                               name, hi, lo, exp_hi, exp_lo);
        end
        if (!leave_done) begin
            tick();
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++; $display("FAIL %s_done_width: done=%b required 0", name, done);
            end
        end
    endtask

    task automatic test_mult();
        model_apply(1, 32'hFFFF_FFFF, 32'd2);
        test_md_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        model_apply(0, 32'hFFFF_FFFF, 32'd3);
        test_md_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    endtask

    task automatic test_back_to_back();
        model_apply(2, 32'hFFFF_FFF9, 32'd2);
        test_md_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        // DIVU issued in the done cycle
        model_apply(3, 32'd7, 32'd2);
        test_md_op("divu_b2b", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    endtask

    task automatic test_div_special();
        model_apply(2, 32'h8000_0000, 32'hFFFF_FFFF);
        test_md_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        model_apply(2, 32'h1234_5678, 32'd0);
        test_md_op("div_zero", 3'd2, 32'h1234_5678, 32'd0, 32'd0, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_hazard();
        int k;
        bit bad;
        d_md = 1'b1;
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL stall_issue: got %b required 1", stall);
        end
        tick();
        start = 1'b0; op = 3'd7;
        model_apply(0, 32'd6, 32'd7);
        bad = 1'b0;
        for (k = 0; k < 64 && done !== 1'b1; k++) begin
            if (stall !== 1'b1) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad || k != int'(MULT_N)) begin
            n_fail++; $display("FAIL stall_busy: gaps=%b cycles=%0d required gaps=0 cycles=%0d",
                               bad, k, MULT_N);
        end
        n_checks++;
        if (stall !== 1'b0 || lo !== 32'd42) begin
            n_fail++; $display("FAIL stall_done: stall=%b lo=%h required 0 0000002a", stall, lo);
        end
        tick();
        start = 1'b1; op = 3'd5; a = 32'h0000_1234; b = 32'd0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL stall_mtlo: got %b required 0", stall);
        end
        tick();
        start = 1'b0; op = 3'd7;
        model_apply(5, 32'h0000_1234, 32'd0);
        n_checks++;
        if (lo !== 32'h0000_1234 || hi !== m_hi || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mtlo_write: lo=%h hi=%h busy=%b done=%b required lo=00001234 hi=%h 0 0",
                               lo, hi, busy, done, m_hi);
        end
        d_md = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        bit saw;
        issue(3'd2, 32'd100, 32'd7);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h done=%b required all 0",
                               busy, hi, lo, done);
        end
        saw = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
            tick();
        end
        n_checks++;
        if (saw) begin
            n_fail++; $display("FAIL reset_mid_quiet: activity=%b required 0", saw);
        end
        model_apply(0, 32'hFFFF_FFFE, 32'h0001_0003);
        test_md_op("mult_after_reset", 3'd0, 32'hFFFF_FFFE, 32'h0001_0003, m_hi, m_lo, 1'b0);
    endtask

    // Random ops, with an illegal start injected mid-operation now and then
    task automatic test_random();
        int cyc, bc, n;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bit inject;
        for (int it = 0; it < 40; it++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if (rop <= 3'd3) begin
                n = rop[1] ? DIV_N : MULT_N;
                inject = ($urandom_range(0, 1) == 1);
                issue(rop, ra, rb);
                if (inject) begin
                    issue(3'($urandom_range(0, 5)), $urandom, $urandom);
                    n = n - 1;
                end
                model_apply(int'(rop), ra, rb);
                wait_done(cyc, bc);
                n_checks++;
                if (cyc != n || bc != n) begin
                    n_fail++; $display("FAIL rand_%0d_timing op=%0d: cyc=%0d busy=%0d required %0d",
                                       it, rop, cyc, bc, n);
                end
                n_checks++;
                if (hi !== m_hi || lo !== m_lo) begin
                    n_fail++; $display("FAIL rand_%0d_result op=%0d a=%h b=%h: hi=%h lo=%h required hi=%h lo=%h",
                                       it, rop, ra, rb, hi, lo, m_hi, m_lo);
                end
                if ($urandom_range(0, 1) == 1) tick();
            end else begin
                issue(rop, ra, rb);
                model_apply(int'(rop), ra, rb);
                n_checks++;
                if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++; $display("FAIL rand_%0d_imm op=%0d: hi=%h lo=%h busy=%b done=%b required hi=%h lo=%h 0 0",
                                       it, rop, hi, lo, busy, done, m_hi, m_lo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div_special();
        test_hazard();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
